// File: rtl/btn_sw_input.sv
// btn_sw_input: bus-slave front end for the board switches and buttons.
// Synchronises and debounces the raw pins, latches button presses as sticky
// write-1-to-clear pending bits, and raises a maskable level interrupt.
// Register reads are combinational (zero-cycle latency) and side-effect free.
//
// Ports
//   clk     CPU clock, the only clock
//   rst     asynchronous reset, active-low
//   sw_in   raw switch pins (asynchronous)
//   btn_in  raw button pins (asynchronous), 1 = pressed
//   addr    byte offset from the bridge; addr[3:2] selects the register
//   wen     write strobe, one cycle per store
//   wdata   store data
//   rdata   read data, combinational from addr and register state
//   irq     registered level interrupt, |(pend & mask)
//
// Register map (aliases every 16 bytes)
//   0x0 SW   RO   {0, sw_stable}
//   0x4 BTN  RO   {0, btn_stable}
//   0x8 PEND W1C  {0, btn_pend}
//   0xC MASK RW   {0, btn_mask}
module btn_sw_input #(
    parameter int unsigned SW_W     = 24,
    parameter int unsigned BTN_W    = 5,
    parameter int unsigned DEBOUNCE = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [BTN_W-1:0] btn_in,
    input  logic [11:0]      addr,
    input  logic             wen,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int unsigned IN_W  = SW_W + BTN_W;
    localparam int unsigned CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    localparam logic [1:0] REG_SW   = 2'b00;
    localparam logic [1:0] REG_BTN  = 2'b01;
    localparam logic [1:0] REG_PEND = 2'b10;
    localparam logic [1:0] REG_MASK = 2'b11;

    // Switches occupy the low bits, buttons the high bits of every per-pin vector.
    logic [IN_W-1:0]  sync1_q, sync2_q;
    logic [IN_W-1:0]  samp_q, samp_d;
    logic [IN_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BTN_W-1:0] btn_prev_q;
    logic [BTN_W-1:0] pend_q, pend_d;
    logic [BTN_W-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;

    logic             tick_c;
    logic [IN_W-1:0]  diff_c;
    logic [BTN_W-1:0] btn_stable_c;
    logic [BTN_W-1:0] press_c;
    logic [BTN_W-1:0] clr_c;

    // Address and data bits outside the decode are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[11:4], addr[1:0], wdata[31:BTN_W]};

    // Next-state logic: prescaler, debounce, press detect, PEND/MASK, irq.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        samp_d       = samp_q;
        stable_d     = stable_q;
        pend_d       = pend_q;
        mask_d       = mask_q;
        irq_d        = 1'b0;
        clr_c        = '0;

        tick_c       = (tick_cnt_q == CNT_W'(DEBOUNCE - 1));
        diff_c       = sync2_q ^ samp_q;
        btn_stable_c = stable_q[IN_W-1:SW_W];
        press_c      = btn_stable_c & ~btn_prev_q;

        tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);

        // A bit is accepted only when two consecutive tick samples agree.
        if (tick_c) begin
            samp_d   = sync2_q;
            stable_d = (sync2_q & ~diff_c) | (stable_q & diff_c);
        end

        if (wen && (addr[3:2] == REG_PEND)) begin
            clr_c = wdata[BTN_W-1:0];
        end
        if (wen && (addr[3:2] == REG_MASK)) begin
            mask_d = wdata[BTN_W-1:0];
        end

        // A press in the same cycle as its clear keeps the bit set.
        pend_d = press_c | (pend_q & ~clr_c);
        irq_d  = |(pend_d & mask_d);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            samp_q     <= '0;
            stable_q   <= '0;
            tick_cnt_q <= '0;
            btn_prev_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= {btn_in, sw_in};
            sync2_q    <= sync1_q;
            samp_q     <= samp_d;
            stable_q   <= stable_d;
            tick_cnt_q <= tick_cnt_d;
            btn_prev_q <= stable_q[IN_W-1:SW_W];
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end

    // Combinational read mux; unused upper bits read as zero.
    always_comb begin
        rdata = '0;
        unique case (addr[3:2])
            REG_SW:   rdata = 32'(stable_q[SW_W-1:0]);
            REG_BTN:  rdata = 32'(stable_q[IN_W-1:SW_W]);
            REG_PEND: rdata = 32'(pend_q);
            REG_MASK: rdata = 32'(mask_q);
            default:  rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_btn_sw_input.sv
// Testbench for btn_sw_input (DEBOUNCE = 4): directed scenarios followed by
// random pin/bus traffic, all compared every cycle against a reference model.
module tb_btn_sw_input;

    localparam int unsigned SW_W  = 24;
    localparam int unsigned BTN_W = 5;
    localparam int unsigned DEB   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [SW_W-1:0]  sw_in;
    logic [BTN_W-1:0] btn_in;
    logic [11:0]      addr;
    logic             wen;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             irq;

    int n_checks = 0;
    int n_errors = 0;

    btn_sw_input #(.SW_W(SW_W), .BTN_W(BTN_W), .DEBOUNCE(DEB)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .btn_in (btn_in),
        .addr   (addr),
        .wen    (wen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: pins seen after a two-edge delay, sampled every DEB
    // edges; a value is accepted when it equals the previous tick's sample.
    logic [28:0] m_hist [$];
    int          m_edges;
    logic [28:0] m_last_sample;
    logic [28:0] m_accepted;
    logic [4:0]  m_seen;
    logic [4:0]  m_pend;
    logic [4:0]  m_mask;
    logic        m_irq;

    task automatic model_reset();
        m_hist        = {29'd0, 29'd0};
        m_edges       = 0;
        m_last_sample = '0;
        m_accepted    = '0;
        m_seen        = '0;
        m_pend        = '0;
        m_mask        = '0;
        m_irq         = 1'b0;
    endtask

    task automatic model_edge();
        logic [28:0] synced;
        logic [4:0]  presses;
        logic [4:0]  clr;
        logic [28:0] acc_old;
        if (!rst) begin
            model_reset();
            return;
        end
        synced  = m_hist[0];
        acc_old = m_accepted;
        presses = acc_old[28:24] & ~m_seen;
        m_seen  = acc_old[28:24];
        if ((m_edges % DEB) == DEB - 1) begin
            for (int b = 0; b < 29; b++)
                if (synced[b] == m_last_sample[b]) m_accepted[b] = synced[b];
            m_last_sample = synced;
        end
        m_edges++;
        void'(m_hist.pop_front());
        m_hist.push_back({btn_in, sw_in});
        clr = (wen && addr[3:2] == 2'd2) ? wdata[4:0] : 5'd0;
        if (wen && addr[3:2] == 2'd3) m_mask = wdata[4:0];
        m_pend = presses | (m_pend & ~clr);
        m_irq  = |(m_pend & m_mask);
    endtask

    function automatic logic [31:0] model_read(input int r);
        case (r)
            0:       return {8'd0, m_accepted[23:0]};
            1:       return {27'd0, m_accepted[28:24]};
            2:       return {27'd0, m_pend};
            default: return {27'd0, m_mask};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read one register through a random alias of its offset.
    task automatic rd(input int r, output logic [31:0] v);
        addr = {8'($urandom_range(0, 255)), 2'(r), 2'($urandom_range(0, 3))};
        #1;
        v = rdata;
    endtask

    task automatic check_all();
        logic [31:0] v;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        for (int r = 0; r < 4; r++) begin
            rd(r, v);
            chk($sformatf("reg%0d", r), v, model_read(r));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic step(input logic [23:0] s, input logic [4:0] b, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
        sw_in = s; btn_in = b; wen = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        wen = 1'b0;
    endtask

    task automatic idle(input int n, input logic [23:0] s, input logic [4:0] b);
        for (int i = 0; i < n; i++) step(s, b, 1'b0, 12'h0, 32'h0);
    endtask

    logic [31:0] v;
    logic [23:0] cur_sw;
    logic [4:0]  cur_btn;
    bit          hit;

    initial begin
        rst = 1'b0; sw_in = '1; btn_in = '0; addr = '0; wen = 1'b0; wdata = '0;
        model_reset();
        #1;
        // Reset with all switches high: everything reads zero.
        check_all();
        rd(0, v); chk("rst_sw", v, 32'h0);
        idle(3, 24'hFFFFFF, 5'h0);
        rst = 1'b1;
        idle(12, 24'hFFFFFF, 5'h0);
        rd(0, v);  chk("sw_after_ticks", v, 32'h00FFFFFF);
        chk("irq_after_reset", {31'd0, irq}, 32'h0);

        // Short 3-cycle glitch on button 2 is rejected.
        idle(3, 24'hFFFFFF, 5'h04);
        idle(12, 24'hFFFFFF, 5'h00);
        rd(1, v); chk("glitch_btn", v, 32'h0);
        rd(2, v); chk("glitch_pend", v, 32'h0);

        // Long press with MASK = 4.
        step(24'hFFFFFF, 5'h04, 1'b1, 12'h00C, 32'h4);
        idle(14, 24'hFFFFFF, 5'h04);
        rd(1, v); chk("press_btn", v, 32'h4);
        rd(2, v); chk("press_pend", v, 32'h4);
        chk("press_irq", {31'd0, irq}, 32'h1);
        idle(14, 24'hFFFFFF, 5'h00);
        rd(2, v); chk("release_pend", v, 32'h4);

        // W1C clears PEND and drops irq; then masked press gives no irq.
        step(24'hFFFFFF, 5'h00, 1'b1, 12'h008, 32'h4);
        idle(1, 24'hFFFFFF, 5'h00);
        rd(2, v); chk("w1c_pend", v, 32'h0);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
        step(24'hFFFFFF, 5'h00, 1'b1, 12'h00C, 32'h0);
        idle(14, 24'hFFFFFF, 5'h04);
        rd(2, v); chk("masked_pend", v, 32'h4);
        chk("masked_irq", {31'd0, irq}, 32'h0);
        idle(14, 24'hFFFFFF, 5'h00);
        step(24'hFFFFFF, 5'h00, 1'b1, 12'h008, 32'h1F);

        // Press on bit 0 in the very cycle that bit 0 is written-1-to-clear.
        step(24'hFFFFFF, 5'h00, 1'b1, 12'h00C, 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_accepted[24] && !m_seen[0]) begin
                step(24'hFFFFFF, 5'h01, 1'b1, 12'h008, 32'h1);
                hit = 1'b1;
            end else begin
                idle(1, 24'hFFFFFF, 5'h01);
            end
        end
        if (!hit) begin
            n_checks++; n_errors++;
            $error("FAIL evt_timeout observed no_event expected event_within_40");
        end
        rd(2, v); chk("setwins_pend", v, 32'h1);
        chk("setwins_irq", {31'd0, irq}, 32'h1);

        // Store to RO SW is ignored; high address bits alias.
        step(24'hFFFFFF, 5'h01, 1'b1, 12'h000, 32'hDEADBEEF);
        rd(0, v); chk("ro_sw", v, 32'h00FFFFFF);
        addr = 12'h01C; #1;
        chk("alias_mask", rdata, 32'h1);
        idle(14, 24'hFFFFFF, 5'h00);

        // Reset in the middle of debouncing a press, button held afterwards.
        idle(5, 24'hFFFFFF, 5'h08);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        idle(2, 24'hFFFFFF, 5'h08);
        rst = 1'b1;
        idle(14, 24'hFFFFFF, 5'h08);
        rd(2, v); chk("rst_mid_pend", v, 32'h8);
        idle(14, 24'hFFFFFF, 5'h00);
        rd(2, v); chk("rst_mid_no_dup", v, 32'h8);

        // Random pin activity and bus traffic.
        cur_sw  = 24'($urandom);
        cur_btn = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) cur_sw = 24'($urandom);
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 7) == 0) cur_btn[b] = ~cur_btn[b];
            step(cur_sw, cur_btn, ($urandom_range(0, 4) == 0),
                 12'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
